// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/gnt + rvalid fetch with one
// outstanding request, and drives the IF/ID register with a skid for decode stalls.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | request issued at pc, waiting for gnt
// RSP   | granted, waiting for rvalid
// HOLD  | response parked in skid register until decode accepts
// DROP  | squashed fetch outstanding, discard its response
module if_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            if_id_valid_o,
   output logic [31:0]     if_id_instr_o,
   output logic [6:0]      if_id_opcode_o,
   output logic [XLEN-1:0] if_id_pc_o,
   output logic [XLEN-1:0] if_id_pc4_o
);

   typedef enum logic [1:0] {S_REQ, S_RSP, S_HOLD, S_DROP} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic [31:0]     skid_q;
   logic            armed_q;
   logic            load_ifid;
   logic            skid_we;
   logic [31:0]     load_instr;

   assign pc_plus4 = pc_q + XLEN'(4);

   // armed_q keeps req low through reset and lets it rise on the first clock after release
   assign imem_req_o  = (state_q == S_REQ) && armed_q;
   assign imem_addr_o = pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      load_ifid  = 1'b0;
      skid_we    = 1'b0;
      load_instr = imem_rdata_i;
      case (state_q)
         S_REQ: begin
            if (armed_q && imem_gnt_i)
               state_d = flush_i ? S_DROP : S_RSP;
         end
         S_RSP: begin
            if (flush_i) begin
               state_d = imem_rvalid_i ? S_REQ : S_DROP;
            end else if (imem_rvalid_i) begin
               if (stall_i) begin
                  skid_we = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  load_ifid = 1'b1;
                  state_d   = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (flush_i) begin
               state_d = S_REQ;
            end else if (!stall_i) begin
               load_ifid  = 1'b1;
               load_instr = skid_q;
               state_d    = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i)
               state_d = S_REQ;
         end
      endcase
      if (flush_i)
         pc_d = redirect_pc_i & ~XLEN'(3);
      else if (load_ifid)
         pc_d = pc_plus4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         armed_q <= 1'b0;
         skid_q  <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         armed_q <= 1'b1;
         if (flush_i)
            skid_q <= NOP_INSTR;
         else if (skid_we)
            skid_q <= imem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_valid_o  <= 1'b0;
         if_id_instr_o  <= NOP_INSTR;
         if_id_opcode_o <= NOP_INSTR[6:0];
         if_id_pc_o     <= '0;
         if_id_pc4_o    <= '0;
      end else if (flush_i) begin
         if_id_valid_o  <= 1'b0;
         if_id_instr_o  <= NOP_INSTR;
         if_id_opcode_o <= NOP_INSTR[6:0];
      end else if (load_ifid) begin
         if_id_valid_o  <= 1'b1;
         if_id_instr_o  <= load_instr;
         if_id_opcode_o <= load_instr[6:0];
         if_id_pc_o     <= pc_q;
         if_id_pc4_o    <= pc_plus4;
      end
   end

endmodule
